port_bus_arbiter: RTL

PORT_BUS_ARBITER -- requirements
Module: port_bus_arbiter

---
 rtl/port_bus_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/port_bus_arbiter.sv
// Shared tristate port arbiter for three requesters: host drive (0), counter display
// drive (1) and pad capture (2). Ownership changes always pass through a turnaround
// window with the pad drivers disabled. Round-robin selection starts after the last owner.
// Optional hold-time preemption is enabled by defining PORT_ARB_TIMEOUT_EN.
module port_bus_arbiter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned MAX_HOLD    = 256
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] drv_data0,
    input  logic [WIDTH-1:0] drv_data1,
    input  logic [WIDTH-1:0] port_in,
    output logic [2:0]       grant,
    output logic [WIDTH-1:0] port_out,
    output logic             port_oe,
    output logic [WIDTH-1:0] cap_data,
    output logic             cap_valid,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StTurn, StOwn} state_e;

    localparam logic [3:0] TurnLast = 4'(TURN_CYCLES - 1);
`ifdef PORT_ARB_TIMEOUT_EN
    localparam logic [15:0] HoldLast = 16'(MAX_HOLD - 1);
`endif

    state_e           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       turn_q, turn_d;
    logic [2:0]       grant_q, grant_d;
    logic [WIDTH-1:0] cap_data_q, cap_data_d;
    logic             cap_valid_q, cap_valid_d;
`ifdef PORT_ARB_TIMEOUT_EN
    logic [15:0]      hold_q, hold_d;
`endif

    // Pick the first set request searching from last+1 mod 3.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] r);
        logic [1:0] c0, c1, c2;
        case (last)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        if (r[c0])      rr_pick = c0;
        else if (r[c1]) rr_pick = c1;
        else            rr_pick = c2;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        onehot = 3'b001 << idx;
    endfunction

    // Next-state logic: arbitration, turnaround timing and release/preemption.
    always_comb begin
        logic [2:0] others;
        logic       release_own;
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        turn_d      = turn_q;
`ifdef PORT_ARB_TIMEOUT_EN
        hold_d      = hold_q;
`endif
        others      = req & ~onehot(owner_q);
        release_own = 1'b0;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    owner_d = rr_pick(last_q, req);
                    turn_d  = 4'd0;
                    state_d = StTurn;
                end
            end
            StTurn: begin
                if (!req[owner_q]) begin
                    // Requester withdrew before grant: no ownership recorded.
                    state_d = StIdle;
                    turn_d  = 4'd0;
                end else if (turn_q == TurnLast) begin
                    state_d = StOwn;
`ifdef PORT_ARB_TIMEOUT_EN
                    hold_d  = 16'd0;
`endif
                end else begin
                    turn_d = turn_q + 4'd1;
                end
            end
            StOwn: begin
                release_own = !req[owner_q];
`ifdef PORT_ARB_TIMEOUT_EN
                if (hold_q == HoldLast) begin
                    if (|others) release_own = 1'b1;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
`endif
                if (release_own) begin
                    last_d = owner_q;
                    turn_d = 4'd0;
                    if (|others) begin
                        owner_d = rr_pick(owner_q, others);
                        state_d = StTurn;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Grant and capture next values; grant rises on the same edge that enters OWN.
    always_comb begin
        grant_d     = (state_d == StOwn) ? onehot(owner_d) : 3'b000;
        cap_valid_d = (state_q == StOwn) && (owner_q == 2'd2);
        cap_data_d  = cap_valid_d ? port_in : cap_data_q;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_q     <= 2'd0;
            last_q      <= 2'd2;
            turn_q      <= 4'd0;
            grant_q     <= 3'b000;
            cap_data_q  <= '0;
            cap_valid_q <= 1'b0;
`ifdef PORT_ARB_TIMEOUT_EN
            hold_q      <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            turn_q      <= turn_d;
            grant_q     <= grant_d;
            cap_data_q  <= cap_data_d;
            cap_valid_q <= cap_valid_d;
`ifdef PORT_ARB_TIMEOUT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    // Pad drive derived from registered state only, so reset kills it on the next edge.
    always_comb begin
        port_oe  = (state_q == StOwn) && (owner_q != 2'd2);
        port_out = '0;
        if (port_oe) port_out = (owner_q == 2'd0) ? drv_data0 : drv_data1;
        grant     = grant_q;
        cap_data  = cap_data_q;
        cap_valid = cap_valid_q;
        busy      = (state_q != StIdle);
    end

endmodule
